simd_mac_pipe: RTL
==================

// Module: simd_mac_pipe
// PURPOSE
//  Parametrised two-stage multiply-accumulate with guard bits. Supports a full-width signed
//  mode and a split mode of two independent half-width lanes, plus saturation and pipeline stall.
//  It sits in the datapath between the operand fetch logic and the writeback register.
// PARAMETERS
//  DATA_W   16  operand width; must be even; each split lane is DATA_W/2 bits wide
//  GUARD_W   8  accumulator guard bits; must be even; each split lane gets GUARD_W/2
// PORTS
//  clk           in   1          rising-edge clock
//  reset_n       in   1          synchronous active-low reset
//  instruction   in   3          [2]=split mode; [1:0] 00 clear, 01 load, 10 accumulate, 11 saturate
//  multiplier    in   DATA_W     signed operand A
//  multiplicand  in   DATA_W     signed operand B
//  stall         in   1          high: freeze the whole pipeline
//  result        out  2*DATA_W   accumulator low bits
//  protect       out  GUARD_W    accumulator guard bits
//  sat_flag      out  1          only present with SIMD_MAC_SAT_FLAG_EN
// BEHAVIOUR
//  - ACC_W = 2*DATA_W; the accumulator is {protect,result}, ACC_W+GUARD_W bits, signed.
//  - Reset: reset_n low at a posedge clears all stage registers, result, protect and sat_flag to 0.
//    Reset has priority over stall. An operation in flight at reset is discarded.
//  - S1, at the edge where stall=0:
//    - register the instruction.
//    - register the full product A*B (ACC_W bits, signed).
//    - register lane0 product A[H-1:0]*B[H-1:0] and lane1 product A[2H-1:H]*B[2H-1:H], H=DATA_W/2,
//      each DATA_W bits, signed.
//  - S2, at the next edge where stall=0: update the accumulator from the S1 registers.
//  - Latency: operands sampled at edge E appear on result/protect after edge E+1. Throughput is 1/cycle.
//  - stall=1: S1, S2 and the outputs hold. Inputs in a stalled cycle are ignored. No bubble is inserted.
//  - Full mode (instruction[2]=0):
//    - 00 clear: acc=0.
//    - 01 load: acc=sign-extended product.
//    - 10 accumulate: acc+=product, wrapping modulo 2^(ACC_W+GUARD_W).
//    - 11 saturate: if acc > 2^(ACC_W-1)-1, clamp to that value.
//      If acc < -2^(ACC_W-1), clamp to that value. Otherwise hold.
//      Guard bits always become the sign extension of result[ACC_W-1].
//  - Split mode (instruction[2]=1): two independent lanes of DATA_W+GUARD_W/2 bits.
//    - lane0 = {protect[GUARD_W/2-1:0], result[DATA_W-1:0]}.
//    - lane1 = {protect[GUARD_W-1:GUARD_W/2], result[ACC_W-1:DATA_W]}.
//    - Ops are per-lane as in full mode, with clamp limits ±2^(DATA_W-1).
//    - No carry or borrow crosses lanes.
//  - Mode switch without clear: existing accumulator bits are reinterpreted in the new packing
//    with no conversion. This is legal and defined behaviour.
//  - Back-to-back dependent ops (e.g. acc, acc, sat) need no bubbles; S2 always uses the current
//    accumulator value.
// CONFIGURATION
//  SIMD_MAC_SAT_FLAG_EN defined:
//    - adds output sat_flag, reset 0.
//    - set at any S2 saturate that clamps (either lane in split mode); sticky.
//    - cleared only by a clear op or by reset.
//  Undefined: the sat_flag port and its logic are absent; all other behaviour is identical.
// TESTING (DATA_W=16, GUARD_W=8)
//  1 full load: 001, A=3, B=-4 -> two edges later result=32'hFFFFFFF4, protect=8'hFF.
//  2 full accumulate + saturate:
//    - 001 then 010 x3, A=B=16'h7FFF -> result=32'hFFFC0004, protect=8'h00.
//    - then 011 -> result=32'h7FFFFFFF, protect=8'h00.
//  3 split lanes:
//    - 101 then 110 x3, A=B=16'h7F80 -> result=32'hFC040000, protect=8'h01.
//    - then 111 -> result=32'h7FFF7FFF, protect=8'h00; sat_flag=1 if enabled.
//  4 stall: stall=1 for 3 cycles mid-accumulate, with operands changed during the stall ->
//    result/protect frozen; final value equals the unstalled sequence delayed by 3 cycles.
//  5 reset mid-operation: reset_n=0 for one edge after 010 issues -> result=0, protect=0,
//    sat_flag=0; the in-flight op has no later effect.
//  6 clear: 000 after test 3 -> result=0, protect=0, sat_flag=0; a following 111 keeps 0 with no flag.

Source files
------------

// File: rtl/simd_mac_pipe_if.sv
// Operand/instruction and accumulator bus for simd_mac_pipe; master drives operands, slave returns the accumulator.
// sat_flag exists only when SIMD_MAC_SAT_FLAG_EN is defined.
interface simd_mac_pipe_if #(
  parameter int DATA_W  = 16,
  parameter int GUARD_W = 8
);
  logic [2:0]          instruction;
  logic [DATA_W-1:0]   multiplier;
  logic [DATA_W-1:0]   multiplicand;
  logic                stall;
  logic [2*DATA_W-1:0] result;
  logic [GUARD_W-1:0]  protect;
`ifdef SIMD_MAC_SAT_FLAG_EN
  logic                sat_flag;

  modport master (output instruction, multiplier, multiplicand, stall,
                  input  result, protect, sat_flag);
  modport slave  (input  instruction, multiplier, multiplicand, stall,
                  output result, protect, sat_flag);
`else
  modport master (output instruction, multiplier, multiplicand, stall,
                  input  result, protect);
  modport slave  (input  instruction, multiplier, multiplicand, stall,
                  output result, protect);
`endif
endinterface

// File: rtl/simd_mac_pipe.sv
// Two-stage SIMD multiply-accumulate with guard bits (full-width or two split lanes); result one edge after capture.
// stall freezes both stages and the accumulator; SIMD_MAC_SAT_FLAG_EN adds a sticky saturation flag.
module simd_mac_pipe #(
  parameter int DATA_W  = 16,
  parameter int GUARD_W = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  simd_mac_pipe_if.slave bus
);
  localparam int H     = DATA_W / 2;
  localparam int HG    = GUARD_W / 2;
  localparam int ACC_W = 2 * DATA_W;
  localparam int TOT_W = ACC_W + GUARD_W;
  localparam int LW    = DATA_W + HG;

  localparam logic signed [TOT_W-1:0] F_MAX = {{(GUARD_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [TOT_W-1:0] F_MIN = {{(GUARD_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic signed [LW-1:0]    L_MAX = {{(HG+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [LW-1:0]    L_MIN = {{(HG+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [2:0]        s1_instr;
  logic [ACC_W-1:0]  s1_full;
  logic [DATA_W-1:0] s1_p0;
  logic [DATA_W-1:0] s1_p1;
  logic [TOT_W-1:0]  acc;
  logic [TOT_W-1:0]  acc_next;
  logic              sat_hit;
  logic [LW-1:0]     l0_next;
  logic [LW-1:0]     l1_next;
  logic [TOT_W-1:0]  full_next;
  logic              c0, c1, cf;

  // Returns {clamped, new_value}; the saturate op re-derives the guard bits from the low part.
  function automatic logic [TOT_W:0] full_step(input logic [1:0] op, input logic [TOT_W-1:0] cur,
                                               input logic [ACC_W-1:0] prod);
    logic signed [TOT_W-1:0] c, p, n;
    logic clamp;
    c     = cur;
    p     = TOT_W'($signed(prod));
    n     = c;
    clamp = 1'b0;
    case (op)
      2'b00: n = '0;
      2'b01: n = p;
      2'b10: n = c + p;
      default: begin
        if (c > F_MAX) begin
          n = F_MAX; clamp = 1'b1;
        end else if (c < F_MIN) begin
          n = F_MIN; clamp = 1'b1;
        end else begin
          n = TOT_W'($signed(c[ACC_W-1:0]));
        end
      end
    endcase
    return {clamp, n};
  endfunction

  function automatic logic [LW:0] lane_step(input logic [1:0] op, input logic [LW-1:0] cur,
                                            input logic [DATA_W-1:0] prod);
    logic signed [LW-1:0] c, p, n;
    logic clamp;
    c     = cur;
    p     = LW'($signed(prod));
    n     = c;
    clamp = 1'b0;
    case (op)
      2'b00: n = '0;
      2'b01: n = p;
      2'b10: n = c + p;
      default: begin
        if (c > L_MAX) begin
          n = L_MAX; clamp = 1'b1;
        end else if (c < L_MIN) begin
          n = L_MIN; clamp = 1'b1;
        end else begin
          n = LW'($signed(c[DATA_W-1:0]));
        end
      end
    endcase
    return {clamp, n};
  endfunction

  always_comb begin
    acc_next = '0;
    sat_hit  = 1'b0;
    {c0, l0_next}   = lane_step(s1_instr[1:0], {acc[ACC_W+HG-1:ACC_W], acc[DATA_W-1:0]}, s1_p0);
    {c1, l1_next}   = lane_step(s1_instr[1:0], {acc[TOT_W-1:ACC_W+HG], acc[ACC_W-1:DATA_W]}, s1_p1);
    {cf, full_next} = full_step(s1_instr[1:0], acc, s1_full);
    if (s1_instr[2]) begin
      acc_next = {l1_next[LW-1:DATA_W], l0_next[LW-1:DATA_W], l1_next[DATA_W-1:0], l0_next[DATA_W-1:0]};
      sat_hit  = c0 | c1;
    end else begin
      acc_next = full_next;
      sat_hit  = cf;
    end
  end

  // Reset leaves S1 holding a clear op, so a discarded in-flight op cannot resurface.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_instr <= '0;
      s1_full  <= '0;
      s1_p0    <= '0;
      s1_p1    <= '0;
      acc      <= '0;
    end else if (!bus.stall) begin
      s1_instr <= bus.instruction;
      s1_full  <= ACC_W'($signed(bus.multiplier)) * ACC_W'($signed(bus.multiplicand));
      s1_p0    <= DATA_W'($signed(bus.multiplier[H-1:0])) * DATA_W'($signed(bus.multiplicand[H-1:0]));
      s1_p1    <= DATA_W'($signed(bus.multiplier[2*H-1:H])) * DATA_W'($signed(bus.multiplicand[2*H-1:H]));
      acc      <= acc_next;
    end
  end

  assign bus.result  = acc[ACC_W-1:0];
  assign bus.protect = acc[TOT_W-1:ACC_W];

`ifdef SIMD_MAC_SAT_FLAG_EN
  logic sat_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sat_q <= 1'b0;
    end else if (!bus.stall) begin
      if (s1_instr[1:0] == 2'b00) sat_q <= 1'b0;
      else if (sat_hit)           sat_q <= 1'b1;
    end
  end

  assign bus.sat_flag = sat_q;
`else
  logic unused_sat_hit;
  assign unused_sat_hit = sat_hit;
`endif
endmodule
